// File: rtl/rlwe_dmem_arb.sv
// Round-robin arbiter sharing one DMEM port between the pipeline LSU (port 0) and the
// RLWE accelerator (port 1), with single-outstanding tracking and a response timeout.

package rlwe_dmem_arb_pkg;
    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned LANE             = 4;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE   = 2'b00,
        SCR1_MEM_WIDTH_HWORD  = 2'b01,
        SCR1_MEM_WIDTH_WORD   = 2'b10,
        SCR1_MEM_WIDTH_VECTOR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef logic [LANE-1:0][31:0] type_vector;
endpackage

module rlwe_dmem_arb
    import rlwe_dmem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          lsu2arb_req,
    input  type_scr1_mem_cmd_e            lsu2arb_cmd,
    input  type_scr1_mem_width_e          lsu2arb_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   lsu2arb_addr,
    input  type_vector                    lsu2arb_wdata,
    output logic                          arb2lsu_req_ack,
    output type_vector                    arb2lsu_rdata,
    output type_scr1_mem_resp_e           arb2lsu_resp,

    input  logic                          acc2arb_req,
    input  type_scr1_mem_cmd_e            acc2arb_cmd,
    input  type_scr1_mem_width_e          acc2arb_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   acc2arb_addr,
    input  type_vector                    acc2arb_wdata,
    output logic                          arb2acc_req_ack,
    output type_vector                    arb2acc_rdata,
    output type_scr1_mem_resp_e           arb2acc_resp,

    output logic                          arb2dmem_req,
    output type_scr1_mem_cmd_e            arb2dmem_cmd,
    output type_scr1_mem_width_e          arb2dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0]   arb2dmem_addr,
    output type_vector                    arb2dmem_wdata,
    input  logic                          dmem2arb_req_ack,
    input  type_vector                    dmem2arb_rdata,
    input  type_scr1_mem_resp_e           dmem2arb_resp,

    output logic                          arb_busy,
    output logic                          arb_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;
    logic               owner_q, owner_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sel_c;
    logic               grant_c;
    logic               mem_done_c;
    logic               tmo_hit_c;
    type_scr1_mem_resp_e owner_resp_c;
    type_vector          owner_rdata_c;

    // Port selection and zero-cycle request forwarding (only IDLE forwards)
    always_comb begin
        sel_c = 1'b0;
        case ({acc2arb_req, lsu2arb_req})
            2'b01:   sel_c = 1'b0;
            2'b10:   sel_c = 1'b1;
            2'b11:   sel_c = rr_q;
            default: sel_c = 1'b0;
        endcase

        arb2dmem_req   = (sel_c ? acc2arb_req : lsu2arb_req) & (state_q == ST_IDLE);
        arb2dmem_cmd   = sel_c ? acc2arb_cmd   : lsu2arb_cmd;
        arb2dmem_width = sel_c ? acc2arb_width : lsu2arb_width;
        arb2dmem_addr  = sel_c ? acc2arb_addr  : lsu2arb_addr;
        arb2dmem_wdata = sel_c ? acc2arb_wdata : lsu2arb_wdata;

        grant_c    = arb2dmem_req & dmem2arb_req_ack;
        mem_done_c = (dmem2arb_resp == SCR1_MEM_RESP_RDY_OK) ||
                     (dmem2arb_resp == SCR1_MEM_RESP_RDY_ER);
        // A real response in the deadline cycle wins over the forced error
        tmo_hit_c  = (TIMEOUT_CYC != 0) && (state_q == ST_BUSY) && !mem_done_c &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d = sel_c;
                    rr_d    = ~sel_c;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_done_c) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (tmo_hit_c) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Response routing: only the owner of a BUSY transaction sees memory
    always_comb begin
        arb2lsu_req_ack = grant_c & ~sel_c;
        arb2acc_req_ack = grant_c &  sel_c;

        owner_resp_c  = SCR1_MEM_RESP_NOTRDY;
        owner_rdata_c = '0;
        if (state_q == ST_BUSY) begin
            if (tmo_hit_c) begin
                owner_resp_c = SCR1_MEM_RESP_RDY_ER;
            end else begin
                owner_resp_c  = dmem2arb_resp;
                owner_rdata_c = dmem2arb_rdata;
            end
        end

        arb2lsu_resp  = SCR1_MEM_RESP_NOTRDY;
        arb2lsu_rdata = '0;
        arb2acc_resp  = SCR1_MEM_RESP_NOTRDY;
        arb2acc_rdata = '0;
        if (owner_q) begin
            arb2acc_resp  = owner_resp_c;
            arb2acc_rdata = owner_rdata_c;
        end else begin
            arb2lsu_resp  = owner_resp_c;
            arb2lsu_rdata = owner_rdata_c;
        end
    end

    assign arb_busy    = busy_q;
    assign arb_timeout = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_rlwe_dmem_arb.sv
// Directed bench for rlwe_dmem_arb: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT acks or responds.

module tb_rlwe_dmem_arb;
    import rlwe_dmem_arb_pkg::*;

    localparam int unsigned TCYC = 4;
    localparam int unsigned VW   = LANE * 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                        lsu_req, acc_req;
    type_scr1_mem_cmd_e          lsu_cmd, acc_cmd;
    type_scr1_mem_width_e        lsu_width, acc_width;
    logic [SCR1_DMEM_AWIDTH-1:0] lsu_addr, acc_addr;
    type_vector                  lsu_wdata, acc_wdata;
    logic                        lsu_ack, acc_ack;
    type_vector                  lsu_rdata, acc_rdata;
    type_scr1_mem_resp_e         lsu_resp, acc_resp;
    logic                        dm_req;
    type_scr1_mem_cmd_e          dm_cmd;
    type_scr1_mem_width_e        dm_width;
    logic [SCR1_DMEM_AWIDTH-1:0] dm_addr;
    type_vector                  dm_wdata;
    logic                        dm_ack;
    type_vector                  dm_rdata;
    type_scr1_mem_resp_e         dm_resp;
    logic                        busy, tmo;

    rlwe_dmem_arb #(.TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst),
        .lsu2arb_req(lsu_req), .lsu2arb_cmd(lsu_cmd), .lsu2arb_width(lsu_width),
        .lsu2arb_addr(lsu_addr), .lsu2arb_wdata(lsu_wdata),
        .arb2lsu_req_ack(lsu_ack), .arb2lsu_rdata(lsu_rdata), .arb2lsu_resp(lsu_resp),
        .acc2arb_req(acc_req), .acc2arb_cmd(acc_cmd), .acc2arb_width(acc_width),
        .acc2arb_addr(acc_addr), .acc2arb_wdata(acc_wdata),
        .arb2acc_req_ack(acc_ack), .arb2acc_rdata(acc_rdata), .arb2acc_resp(acc_resp),
        .arb2dmem_req(dm_req), .arb2dmem_cmd(dm_cmd), .arb2dmem_width(dm_width),
        .arb2dmem_addr(dm_addr), .arb2dmem_wdata(dm_wdata),
        .dmem2arb_req_ack(dm_ack), .dmem2arb_rdata(dm_rdata), .dmem2arb_resp(dm_resp),
        .arb_busy(busy), .arb_timeout(tmo)
    );

    typedef struct {
        logic                        port;
        logic [SCR1_DMEM_AWIDTH-1:0] addr;
        type_vector                  wdata;
    } grant_t;

    typedef struct {
        logic                port;
        type_scr1_mem_resp_e resp;
        type_vector          rdata;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];
    int     checks   = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic type_vector mkv(input logic [31:0] d);
        type_vector v;
        for (int i = 0; i < int'(LANE); i++) v[i] = d + 32'(i);
        return v;
    endfunction

    task automatic push_grant(input logic p, input logic [SCR1_DMEM_AWIDTH-1:0] a, input type_vector w);
        grant_t g;
        g.port = p; g.addr = a; g.wdata = w;
        gq.push_back(g);
    endtask

    task automatic push_resp(input logic p, input type_scr1_mem_resp_e r, input type_vector d);
        resp_t e;
        e.port = p; e.resp = r; e.rdata = d;
        rq.push_back(e);
    endtask

    // Monitor: every ack or non-NOTRDY response must match the head of its queue
    always @(negedge clk) begin
        grant_t g;
        resp_t  e;
        logic   p;
        if (!rst) begin
            if (lsu_ack || acc_ack) begin
                check("dual_ack", VW'(lsu_ack & acc_ack), VW'(0));
                if (gq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexp_grant actual=lsu%0b/acc%0b required=none t=%0t", lsu_ack, acc_ack, $time);
                end else begin
                    g = gq.pop_front();
                    check("grant_port", VW'(acc_ack), VW'(g.port));
                    check("grant_addr", VW'(dm_addr), VW'(g.addr));
                    check("grant_wdata", VW'(dm_wdata), VW'(g.wdata));
                end
            end
            if (lsu_resp != SCR1_MEM_RESP_NOTRDY || acc_resp != SCR1_MEM_RESP_NOTRDY) begin
                check("dual_resp", VW'((lsu_resp != SCR1_MEM_RESP_NOTRDY) && (acc_resp != SCR1_MEM_RESP_NOTRDY)), VW'(0));
                p = (acc_resp != SCR1_MEM_RESP_NOTRDY);
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexp_resp actual=lsu%0d/acc%0d required=none t=%0t", lsu_resp, acc_resp, $time);
                end else begin
                    e = rq.pop_front();
                    check("resp_port", VW'(p), VW'(e.port));
                    check("resp_code", VW'(p ? acc_resp : lsu_resp), VW'(e.resp));
                    check("resp_rdata", VW'(p ? acc_rdata : lsu_rdata), VW'(e.rdata));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        lsu_req = 1'b0; acc_req = 1'b0;
        lsu_cmd = SCR1_MEM_CMD_RD; acc_cmd = SCR1_MEM_CMD_RD;
        lsu_width = SCR1_MEM_WIDTH_WORD; acc_width = SCR1_MEM_WIDTH_WORD;
        lsu_addr = '0; acc_addr = '0; lsu_wdata = '0; acc_wdata = '0;
        dm_ack = 1'b0; dm_rdata = '0; dm_resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_busy"}, VW'(busy), VW'(0));
        check({tag, "_lsu_resp"}, VW'(lsu_resp), VW'(SCR1_MEM_RESP_NOTRDY));
        check({tag, "_acc_resp"}, VW'(acc_resp), VW'(SCR1_MEM_RESP_NOTRDY));
        check({tag, "_lsu_rdata"}, VW'(lsu_rdata), VW'(0));
        check({tag, "_acc_rdata"}, VW'(acc_rdata), VW'(0));
        check({tag, "_acks"}, VW'({lsu_ack, acc_ack}), VW'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        @(negedge clk);
        chk_idle_outputs("rst");
        check("rst_timeout", VW'(tmo), VW'(0));
        check("rst_dmem_req", VW'(dm_req), VW'(0));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        idle_in();
        #2;

        // Single port LSU load
        do_reset();
        lsu_req = 1'b1; lsu_addr = 32'h100; dm_ack = 1'b1;
        push_grant(1'b0, 32'h100, '0);
        @(negedge clk);
        check("t1_dmem_req", VW'(dm_req), VW'(1));
        tick();
        lsu_req = 1'b0; dm_ack = 1'b0;
        @(negedge clk);
        check("t1_busy", VW'(busy), VW'(1));
        tick();
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'hDEADBEEF);
        push_resp(1'b0, SCR1_MEM_RESP_RDY_OK, mkv(32'hDEADBEEF));
        tick();
        idle_in();
        @(negedge clk);
        check("t1_idle", VW'(busy), VW'(0));

        // Contention: alternating grants starting with port 0
        do_reset();
        for (int t = 0; t < 4; t++) begin
            logic p;
            p = 1'(t % 2);
            lsu_req = 1'b1; acc_req = 1'b1;
            lsu_cmd = SCR1_MEM_CMD_WR; acc_cmd = SCR1_MEM_CMD_WR;
            lsu_addr = 32'h200 + 32'(t); acc_addr = 32'h300 + 32'(t);
            lsu_wdata = mkv(32'hA000 + 32'(t)); acc_wdata = mkv(32'hB000 + 32'(t));
            dm_ack = 1'b1; dm_resp = SCR1_MEM_RESP_NOTRDY; dm_rdata = '0;
            push_grant(p, p ? 32'h300 + 32'(t) : 32'h200 + 32'(t),
                       p ? mkv(32'hB000 + 32'(t)) : mkv(32'hA000 + 32'(t)));
            tick();
            dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'h1000 + 32'(t));
            push_resp(p, SCR1_MEM_RESP_RDY_OK, mkv(32'h1000 + 32'(t)));
            tick();
        end
        idle_in();

        // Memory backpressure keeps rr_ptr on port 0
        do_reset();
        lsu_req = 1'b1; acc_req = 1'b1; lsu_addr = 32'h400; acc_addr = 32'h500;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_dmem_req", VW'(dm_req), VW'(1));
            check("bp_dmem_addr", VW'(dm_addr), VW'(32'h400));
            check("bp_busy", VW'(busy), VW'(0));
            tick();
        end
        dm_ack = 1'b1;
        push_grant(1'b0, 32'h400, '0);
        tick();
        lsu_req = 1'b0; dm_ack = 1'b0;
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'h4444);
        push_resp(1'b0, SCR1_MEM_RESP_RDY_OK, mkv(32'h4444));
        tick();
        dm_resp = SCR1_MEM_RESP_NOTRDY; dm_ack = 1'b1;
        push_grant(1'b1, 32'h500, '0);
        tick();
        acc_req = 1'b0; dm_ack = 1'b0;
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'h5555);
        push_resp(1'b1, SCR1_MEM_RESP_RDY_OK, mkv(32'h5555));
        tick();
        idle_in();

        // Timeout on an accelerator vector store, then drain
        do_reset();
        acc_req = 1'b1; acc_cmd = SCR1_MEM_CMD_WR; acc_width = SCR1_MEM_WIDTH_VECTOR;
        acc_addr = 32'h600; acc_wdata = mkv(32'hC0DE0000); dm_ack = 1'b1;
        push_grant(1'b1, 32'h600, mkv(32'hC0DE0000));
        tick();
        acc_req = 1'b0; dm_ack = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            check("to_busy", VW'(busy), VW'(1));
            check("to_flag_early", VW'(tmo), VW'(0));
            tick();
        end
        push_resp(1'b1, SCR1_MEM_RESP_RDY_ER, '0);
        @(negedge clk);
        check("to_flag_pre", VW'(tmo), VW'(0));
        tick();
        @(negedge clk);
        check("to_drain_busy", VW'(busy), VW'(1));
        check("to_flag_set", VW'(tmo), VW'(1));
        tick();
        lsu_req = 1'b1; lsu_addr = 32'h700; dm_ack = 1'b1;
        @(negedge clk);
        check("to_drain_noreq6", VW'(dm_req), VW'(0));
        tick();
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'h7777);
        @(negedge clk);
        check("to_drain_noreq7", VW'(dm_req), VW'(0));
        tick();
        dm_resp = SCR1_MEM_RESP_NOTRDY; dm_rdata = '0;
        push_grant(1'b0, 32'h700, '0);
        tick();
        lsu_req = 1'b0; dm_ack = 1'b0;
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'h8888);
        push_resp(1'b0, SCR1_MEM_RESP_RDY_OK, mkv(32'h8888));
        @(negedge clk);
        check("to_flag_sticky", VW'(tmo), VW'(1));
        tick();
        idle_in();

        // Memory error is passed through without flagging a timeout
        do_reset();
        lsu_req = 1'b1; lsu_cmd = SCR1_MEM_CMD_WR; lsu_width = SCR1_MEM_WIDTH_BYTE;
        lsu_addr = 32'h800; lsu_wdata = mkv(32'h55); dm_ack = 1'b1;
        push_grant(1'b0, 32'h800, mkv(32'h55));
        tick();
        lsu_req = 1'b0; dm_ack = 1'b0;
        dm_resp = SCR1_MEM_RESP_RDY_ER; dm_rdata = mkv(32'hE1);
        push_resp(1'b0, SCR1_MEM_RESP_RDY_ER, mkv(32'hE1));
        tick();
        idle_in();
        @(negedge clk);
        check("er_flag", VW'(tmo), VW'(0));
        check("er_busy", VW'(busy), VW'(0));

        // Reset mid-BUSY discards the later response and restores rr_ptr
        do_reset();
        lsu_req = 1'b1; lsu_addr = 32'h900; dm_ack = 1'b1;
        push_grant(1'b0, 32'h900, '0);
        tick();
        lsu_req = 1'b0; dm_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_busy_async", VW'(busy), VW'(0));
        tick();
        rst = 1'b0;
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'h9999);
        @(negedge clk);
        chk_idle_outputs("mr_late");
        tick();
        dm_resp = SCR1_MEM_RESP_NOTRDY; dm_rdata = '0;
        lsu_req = 1'b1; acc_req = 1'b1; lsu_addr = 32'hA00; acc_addr = 32'hB00; dm_ack = 1'b1;
        push_grant(1'b0, 32'hA00, '0);
        tick();
        lsu_req = 1'b0; acc_req = 1'b0; dm_ack = 1'b0;
        dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = mkv(32'hAAAA);
        push_resp(1'b0, SCR1_MEM_RESP_RDY_OK, mkv(32'hAAAA));
        tick();
        idle_in();
        tick();

        check("grant_q_empty", VW'(gq.size()), VW'(0));
        check("resp_q_empty", VW'(rq.size()), VW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rlwe_dmem_arb.md
# rlwe_dmem_arb

Two-port arbiter sharing the single data-memory port between the pipeline LSU (port 0) and the RLWE vector accelerator's load/store engine (port 1). It forwards one request at a time using the existing req/req_ack/resp DMEM protocol and round-robin priority. It tracks the single outstanding transaction and routes the response to its owner. A response timeout converts a hung access into an error response.

## Interface
- `TIMEOUT_CYC`, default 255: BUSY cycles without a response before an error response is forced; 0 disables the timeout.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `lsu2arb_req` / `acc2arb_req`  in  1 each  request from port 0 / port 1.
- `lsu2arb_cmd` / `acc2arb_cmd`  in  type_scr1_mem_cmd_e  RD/WR.
- `lsu2arb_width` / `acc2arb_width`  in  type_scr1_mem_width_e  BYTE/HWORD/WORD/VECTOR.
- `lsu2arb_addr` / `acc2arb_addr`  in  `SCR1_DMEM_AWIDTH`  byte address.
- `lsu2arb_wdata` / `acc2arb_wdata`  in  type_vector (`LANE`×32)  store data.
- `arb2lsu_req_ack` / `arb2acc_req_ack`  out  1  request accepted.
- `arb2lsu_rdata` / `arb2acc_rdata`  out  type_vector  load data.
- `arb2lsu_resp` / `arb2acc_resp`  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER.
- `arb2dmem_req`, `arb2dmem_cmd`, `arb2dmem_width`, `arb2dmem_addr`, `arb2dmem_wdata`  out  request to memory, same types as the port inputs.
- `dmem2arb_req_ack`  in  1.
- `dmem2arb_rdata`  in  type_vector.
- `dmem2arb_resp`  in  type_scr1_mem_resp_e.
- `arb_busy`  out  1  state is not IDLE.
- `arb_timeout`  out  1  sticky flag, set on any timeout; cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding, owner registered.
  - DRAIN: a timed-out transaction is still pending at memory.
- Request selection (combinational, IDLE only):
  - Only one port requesting: that port is selected.
  - Both ports requesting: the port indicated by `rr_ptr` is selected.
  - The selected port's cmd/width/addr/wdata drive `arb2dmem_*`. `arb2dmem_req` = (selected port's req) & IDLE.
- Grant: `arb2dmem_req & dmem2arb_req_ack`.
  - `req_ack` is driven to the selected port only, in the same cycle. The other port's `req_ack` is 0.
  - On the clock edge: owner <= selected port; `rr_ptr` <= other port; state -> BUSY; timeout counter <= 0.
  - No grant means `rr_ptr` is unchanged.
- BUSY:
  - `arb2dmem_req` = 0 and both `req_ack` = 0.
  - `dmem2arb_resp` and `dmem2arb_rdata` pass combinationally to the owner. The non-owner sees NOTRDY and rdata = 0.
  - RDY_OK or RDY_ER -> IDLE on the next edge.
  - Otherwise the counter increments. If `TIMEOUT_CYC` != 0 and the counter == `TIMEOUT_CYC`-1 with no response in that cycle:
    - owner gets RDY_ER for that one cycle;
    - `arb_timeout` is set;
    - state -> DRAIN.
- DRAIN:
  - No requests are forwarded; both ports see NOTRDY.
  - The first memory RDY_OK/RDY_ER is discarded -> IDLE.
- IDLE: both ports' resp = NOTRDY. Any memory response arriving in IDLE is ignored and not forwarded.
- Outputs after reset:
  - state IDLE, `rr_ptr` = 0 (port 0 has priority), owner 0, counter 0, `arb_timeout` 0;
  - `arb2dmem_req` = 0 unless a port requests;
  - both resp = NOTRDY, both rdata = 0, both `req_ack` = 0, `arb_busy` = 0.
- Counter width is $clog2(TIMEOUT_CYC+1) bits and saturates; it never wraps.

## Timing
- Zero-cycle request path: a request presented in IDLE reaches memory in the same cycle. The ack returns in the same cycle.
- A response is forwarded in the same cycle it arrives. The next grant can occur no earlier than the cycle after the response.
- A request is held by the requester until it is acked. A request that loses arbitration sees `req_ack` = 0 and stays pending.
- Memory deasserting `req_ack` while a port requests: no grant, no state change, `rr_ptr` unchanged.
- Timeout error pulse appears exactly `TIMEOUT_CYC` cycles after the grant edge. The memory response arriving in that same cycle takes precedence (normal forward, no timeout).
- `rst` asserted mid-transaction: immediate return to the reset values above. A later memory response is discarded because the state is IDLE.

## Test plan
- Single port: LSU LW addr 0x100, mem ack cycle 0, RDY_OK with data 0xDEADBEEF at cycle 2 -> `arb2lsu_resp` RDY_OK with that data at cycle 2; acc sees NOTRDY throughout.
- Contention: both ports request every cycle for 4 transactions, each with a 1-cycle response -> grants alternate LSU, ACC, LSU, ACC; the losing port's `req_ack` = 0.
- Memory backpressure: `dmem2arb_req_ack` = 0 for 3 cycles with both ports requesting -> no grant, `rr_ptr` unchanged; port 0 is granted when the ack rises.
- Timeout: `TIMEOUT_CYC` = 4, ACC SV granted, no response -> `arb2acc_resp` RDY_ER at cycle 4 after the grant, `arb_timeout` = 1, state DRAIN; a memory RDY_OK at cycle 7 is dropped, then IDLE, and an LSU request at cycle 8 is granted.
- Error passthrough: LSU request with memory RDY_ER -> LSU gets RDY_ER, `arb_timeout` stays 0.
- Reset mid-BUSY: assert `rst` one cycle after a grant, then send a memory RDY_OK after release -> both ports see NOTRDY, `arb_busy` = 0, `rr_ptr` = 0.
